ram_fifo_ctrl: RTL

Single-clock FIFO controller that sequences an external `sdp_ram` instance, configured LOW_LATENCY with 1-cycle read latency, into a valid/ready streaming FIFO. It owns the write and read pointers, full/empty tracking and a 2-entry output buffer that absorbs the RAM read latency. The result is a first-word-fall-through interface at full throughput. It sits between a producer and a consumer in the same clock domain; the RAM's `rstb` must be tied 0 and `regceb` left unused.

---
 rtl/ram_fifo_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 1-cycle-latency simple dual-port RAM.
// A 2-entry output buffer hides the RAM read latency so the head word falls through.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
  logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
  logic [ADDR_WIDTH+1:0] count_q, count_d;

  logic [PW-1:0] ram_cnt;
  logic [PW-1:0] ram_cnt_d;
  logic          ram_full;
  logic          ram_empty;
  logic [2:0]    occ;
  logic          pop;
  logic          push;

  assign ram_cnt   = wptr_q - rptr_q;
  assign ram_full  = (ram_cnt == PW'(DEPTH));
  assign ram_empty = (ram_cnt == '0);

  assign s_ready   = ~ram_full & ~flush;
  assign ram_wea   = s_valid & s_ready;
  assign ram_dina  = s_data;
  assign ram_addra = wptr_q[ADDR_WIDTH-1:0];

  assign m_valid   = (obuf_cnt_q != 2'd0);
  assign m_data    = obuf0_q;
  assign pop       = m_valid & m_ready;
  assign push      = inflight_q;

  // Words already committed to the buffer (held + arriving); a read is only
  // issued when its result is guaranteed a free slot next cycle.
  assign occ       = {1'b0, obuf_cnt_q} + {2'b00, inflight_q};
  assign ram_enb   = ~ram_empty & ((occ - {2'b00, pop}) < 3'd2) & ~flush;
  assign ram_addrb = rptr_q[ADDR_WIDTH-1:0];

  assign count     = count_q;

  always_comb begin
    wptr_d     = wptr_q + PW'(ram_wea);
    rptr_d     = rptr_q + PW'(ram_enb);
    inflight_d = ram_enb;
    obuf_cnt_d = obuf_cnt_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;

    // obuf0 is always the head; a pop shifts obuf1 forward.
    case ({push, pop})
      2'b10: begin
        if (obuf_cnt_q == 2'd0) obuf0_d = ram_doutb;
        else                    obuf1_d = ram_doutb;
        obuf_cnt_d = obuf_cnt_q + 2'd1;
      end
      2'b01: begin
        obuf0_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (obuf_cnt_q == 2'd1) begin
          obuf0_d = ram_doutb;
        end else begin
          obuf0_d = obuf1_q;
          obuf1_d = ram_doutb;
        end
      end
      default: ;
    endcase

    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      inflight_d = 1'b0;
      obuf_cnt_d = 2'd0;
    end

    ram_cnt_d = wptr_d - rptr_d;
    count_d   = {1'b0, ram_cnt_d}
              + {{(ADDR_WIDTH+1){1'b0}}, inflight_d}
              + {{ADDR_WIDTH{1'b0}}, obuf_cnt_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      obuf_cnt_q <= 2'd0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      count_q    <= count_d;
    end
  end

endmodule
